// File: rtl/spi_xfer_queue.sv
// Command/response queue in front of spi_master: TX FIFO feeds one transfer
// per entry, received bytes land in an RX FIFO tagged with their slave select.
`timescale 1ns/1ps
module spi_xfer_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [7:0] wr_data,
    output logic       tx_full,
    output logic       wr_drop,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic [1:0] rd_sel,
    output logic       rx_empty,
    output logic       busy,
    output logic       m_start,
    output logic [1:0] m_slave_sel,
    output logic [7:0] m_mosi_data,
    input  logic       m_sending,
    input  logic       m_done,
    input  logic [7:0] m_miso_data
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [9:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wp;
    logic [AW-1:0] tx_rp;
    logic [AW:0]   tx_cnt;
    logic [9:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wp;
    logic [AW-1:0] rx_rp;
    logic [AW:0]   rx_cnt;

    logic tx_push;
    logic launch;
    logic rx_push;
    logic rx_pop;

    assign tx_full  = (tx_cnt == FULL);
    assign rx_empty = (rx_cnt == '0);
    assign rd_data  = rx_mem[rx_rp][7:0];
    assign rd_sel   = rx_mem[rx_rp][9:8];

    // RX space is reserved at launch so a completed transfer always has a slot
    assign tx_push = wr_en && !tx_full;
    assign launch  = (state == IDLE) && (tx_cnt != '0) && (rx_cnt != FULL);
    assign rx_push = (state == WAIT) && m_done;
    assign rx_pop  = rd_en && !rx_empty;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wp] <= {wr_sel, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp   <= '0;
            tx_rp   <= '0;
            tx_cnt  <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && tx_full;
            if (tx_push) begin
                tx_wp <= tx_wp + 1'b1;
            end
            if (launch) begin
                tx_rp <= tx_rp + 1'b1;
            end
            unique case ({tx_push, launch})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem[i] <= '0;
            end
        end else begin
            if (rx_push) begin
                rx_mem[rx_wp] <= {m_slave_sel, m_miso_data};
                rx_wp         <= rx_wp + 1'b1;
            end
            if (rx_pop) begin
                rx_rp <= rx_rp + 1'b1;
            end
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            m_start     <= 1'b0;
            m_slave_sel <= '0;
            m_mosi_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        {m_slave_sel, m_mosi_data} <= tx_mem[tx_rp];
                        m_start <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (m_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    m_start <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    a_start_idle: assert property (
        @(posedge clk) disable iff (!rst_n) m_start |-> !m_sending);
    a_done_wait: assert property (
        @(posedge clk) disable iff (!rst_n) m_done |-> state == WAIT);
    a_rx_room: assert property (
        @(posedge clk) disable iff (!rst_n) rx_push |-> rx_cnt != FULL);

endmodule
